// File: rtl/conv_index_to_mem.sv
// Two-stage pipeline that maps a packed (row, col) pixel index onto a flat byte
// address in image data memory. Indices outside the square image map to OOB_ADDR.
module conv_index_to_mem #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned WORD_SHIFT = 2,
  parameter logic [31:0] OOB_ADDR   = 32'hFFFF_FFFF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  SIZE_IMAGE_SRC,
  input  logic [31:0] INDEX_ADDRESS,
  output logic [31:0] MEM_ADDRESS
);

  // Interface: no handshake. Every rising edge samples SIZE_IMAGE_SRC and
  // INDEX_ADDRESS together, and MEM_ADDRESS holds the result two edges later.

  logic [15:0] row_d;
  logic [15:0] col_d;
  logic [3:0]  sh_d;
  logic [16:0] side_d;
  logic        oob_d;

  logic [15:0] row_q;
  logic [15:0] col_q;
  logic [3:0]  sh_q;
  logic        oob_q;

  logic [31:0] offset;
  logic [31:0] addr_d;

  always_comb begin
    row_d  = INDEX_ADDRESS[31:16];
    col_d  = INDEX_ADDRESS[15:0];
    sh_d   = 4'd6 + {2'b00, SIZE_IMAGE_SRC};
    side_d = 17'd1 << sh_d;
    // 17-bit compare so a 16'hFFFF coordinate can never alias into range
    oob_d  = ({1'b0, row_d} >= side_d) || ({1'b0, col_d} >= side_d);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      row_q <= '0;
      col_q <= '0;
      sh_q  <= '0;
      oob_q <= 1'b0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      sh_q  <= sh_d;
      oob_q <= oob_d;
    end
  end

  // OR is exact here: col < W whenever the index is in range
  always_comb begin
    offset = ({16'h0000, row_q} << sh_q) | {16'h0000, col_q};
    addr_d = oob_q ? OOB_ADDR : (BASE_ADDR + (offset << WORD_SHIFT));
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      MEM_ADDRESS <= '0;
    end else begin
      MEM_ADDRESS <= addr_d;
    end
  end

endmodule

// File: tb/tb_conv_index_to_mem.sv
// Scoreboard bench for conv_index_to_mem: driver pushes hand-computed expected
// addresses, a monitor pops them as each issued index emerges two edges later.
module tb_conv_index_to_mem;

  logic        clk;
  logic        rst_n;
  logic [1:0]  size;
  logic [31:0] index;
  logic [31:0] mem_address;

  logic [31:0] exp_q[$];
  logic        issued;
  int          total;
  int          bad;
  int          popped;
  int          pushed;

  conv_index_to_mem dut (
    .CLK            (clk),
    .RESET          (rst_n),
    .SIZE_IMAGE_SRC (size),
    .INDEX_ADDRESS  (index),
    .MEM_ADDRESS    (mem_address)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: one call per cycle, inputs change on the falling edge
  task automatic drive(input logic [1:0] s, input logic [31:0] idx, input logic [31:0] exp);
    @(negedge clk);
    size   = s;
    index  = idx;
    issued = 1'b1;
    exp_q.push_back(exp);
    pushed++;
  endtask

  task automatic idle();
    @(negedge clk);
    issued = 1'b0;
  endtask

  // monitor: models the 2-edge latency of issued indices and compares
  initial begin : monitor
    logic        v1, v2;
    logic [31:0] e1, e2;
    v1 = 1'b0; v2 = 1'b0; e1 = '0; e2 = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        v1 = 1'b0; v2 = 1'b0;
      end else begin
        v2 = v1; e2 = e1;
        v1 = issued;
        if (issued) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_underflow: got empty queue expected entry");
            v1 = 1'b0;
          end else begin
            e1 = exp_q.pop_front();
            popped++;
          end
        end
      end
      #1;
      if (v2) check("pipe_out", mem_address, e2);
    end
  end

  initial begin
    total = 0; bad = 0; pushed = 0; popped = 0;
    issued = 1'b0;
    rst_n  = 1'b0;
    size   = 2'b10;
    index  = 32'h0000_0002;

    // 1: reset held, then first input after release
    #3;  check("reset_hold_a", mem_address, 32'h0);
    #14; check("reset_hold_b", mem_address, 32'h0);
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    issued = 1'b1;
    exp_q.push_back(32'h0000_0008);
    pushed++;
    @(posedge clk); #1;
    check("post_release_edge1", mem_address, 32'h0);
    drive(2'b10, 32'h0000_0002, 32'h0000_0008);

    // 2-4: out-of-range and in-range at W=256
    drive(2'b10, 32'h0100_0002, 32'hFFFF_FFFF);
    drive(2'b10, 32'h0000_0100, 32'hFFFF_FFFF);
    drive(2'b10, 32'h0000_0001, 32'h0000_0004);
    drive(2'b10, 32'h00FF_00FF, 32'h0003_FFFC);

    // 5: each image size, boundaries
    drive(2'b00, 32'h0001_0000, 32'h0000_0100);
    drive(2'b01, 32'h0001_0000, 32'h0000_0200);
    drive(2'b11, 32'h0001_0000, 32'h0000_0800);
    drive(2'b00, 32'h0000_0040, 32'hFFFF_FFFF);
    drive(2'b00, 32'h003F_003F, 32'h0000_3FFC);
    drive(2'b00, 32'h0040_0000, 32'hFFFF_FFFF);
    drive(2'b11, 32'h01FF_01FF, 32'h000F_FFFC);
    drive(2'b11, 32'h0200_0000, 32'hFFFF_FFFF);
    drive(2'b11, 32'hFFFF_0000, 32'hFFFF_FFFF);
    drive(2'b01, 32'h0000_FFFF, 32'hFFFF_FFFF);
    idle();
    idle();
    idle();

    // 6: back-to-back stream, then reset mid-stream
    drive(2'b01, 32'h0003_0005, 32'h0000_0614);
    drive(2'b10, 32'h0010_0020, 32'h0000_4080);
    drive(2'b01, 32'h007F_007F, 32'h0000_FFFC);
    drive(2'b00, 32'h0002_0003, 32'h0000_020C);
    drive(2'b10, 32'h0000_0002, 32'h0000_0008);
    idle();
    @(posedge clk); #1;
    check("pre_reset_out", mem_address, 32'h0000_0008);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", mem_address, 32'h0);
    @(posedge clk); #1;
    check("reset_held_edge", mem_address, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b11, 32'h0001_0001, 32'h0000_0804);
    idle();
    idle();
    idle();

    total++;
    if (exp_q.size() != 0 || popped != pushed) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left, %0d popped expected 0 left, %0d popped",
               exp_q.size(), popped, pushed);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
